// File: rtl/jtag_reg_bridge.sv
// rtl/jtag_reg_bridge.sv - JTAG user-chain to register bus bridge
//
// Purpose: a TAP user data register carries {wdata, addr, wr} command frames
// in on tap_tdi and returns {rdata_q, status} on tap_tdo. An update strobe
// starts one register bus access, which ends on bus_ack or after TIMEOUT cycles.
//
// Ports:
//   clk, reset                  gated TCK, asynchronous active-high reset
//   tap_sel                     user chain selected
//   tap_capture, tap_shift,     data-register strobes
//   tap_update, tap_tdi         and serial data in
//   tap_tdo                     serial data out (sr[0])
//   bus_req, bus_wr             access request, 1 = write
//   bus_addr, bus_wdata         access address and write data
//   bus_ack, bus_rdata          access complete, read data valid with ack

module jtag_reg_bridge #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tap_sel,
    input  logic              tap_capture,
    input  logic              tap_shift,
    input  logic              tap_update,
    input  logic              tap_tdi,
    output logic              tap_tdo,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int F  = 1 + ADDR_W + DATA_W;
    localparam int SW = ADDR_W + 1;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] CNT_MAX  = 8'(TIMEOUT);

    typedef enum logic {IDLE, REQ} state_t;

    state_t            state_q, state_d;
    logic [F-1:0]      sr;
    logic [DATA_W-1:0] rdata_q;
    logic              timeout_flag, overrun_flag;
    logic [7:0]        cnt_q;
    logic [SW-1:0]     status;

    logic do_cap, do_shift, do_upd;
    logic latch_cmd, ack_done, tmo_evt, ovr_evt;

    // Strobe priority: capture beats shift, shift beats update.
    assign do_cap   = tap_sel & tap_capture;
    assign do_shift = tap_sel & tap_shift & ~tap_capture;
    assign do_upd   = tap_sel & tap_update & ~tap_capture & ~tap_shift;

    assign tap_tdo = sr[0];
    assign bus_req = (state_q == REQ);

    always_comb begin
        status    = '0;
        status[0] = (state_q != IDLE);
        status[1] = timeout_flag;
        status[2] = overrun_flag;
    end

    always_comb begin
        state_d   = state_q;
        latch_cmd = 1'b0;
        ack_done  = 1'b0;
        tmo_evt   = 1'b0;
        ovr_evt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (do_upd) begin
                    latch_cmd = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                // A new command while busy is dropped, the access carries on.
                if (do_upd)
                    ovr_evt = 1'b1;
                // Ack on the expiry cycle takes precedence over the timeout.
                if (bus_ack) begin
                    ack_done = 1'b1;
                    state_d  = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    tmo_evt = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr <= '0;
        end else if (do_cap) begin
            sr <= {rdata_q, status};
        end else if (do_shift) begin
            sr <= {tap_tdi, sr[F-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_wr    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else if (latch_cmd) begin
            bus_wr    <= sr[0];
            bus_addr  <= sr[ADDR_W:1];
            bus_wdata <= sr[F-1:ADDR_W+1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (latch_cmd) begin
            cnt_q <= '0;
        end else if (state_q == REQ && !bus_ack && cnt_q < CNT_MAX) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (ack_done && !bus_wr) begin
            rdata_q <= bus_rdata;
        end
    end

    // Read-to-clear flags; an event coinciding with capture survives it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_flag <= 1'b0;
            overrun_flag <= 1'b0;
        end else if (do_cap) begin
            timeout_flag <= tmo_evt;
            overrun_flag <= ovr_evt;
        end else begin
            timeout_flag <= timeout_flag | tmo_evt;
            overrun_flag <= overrun_flag | ovr_evt;
        end
    end

endmodule

// File: doc/jtag_reg_bridge.md
JTAG_REG_BRIDGE -- requirements
Module: jtag_reg_bridge

Interface
REQ-001 Parameters: ADDR_W, default 4, register address width, minimum 2.
REQ-002 Parameters: DATA_W, default 8, register data width, minimum 1.
REQ-003 Parameters: TIMEOUT, default 15, maximum cycles bus_req waits for bus_ack, range 1..255.
REQ-004 Ports: clk  in  1  TAP data-register clock (gated TCK); the block's only clock.
REQ-005 Ports: reset  in  1  asynchronous, active-high reset.
REQ-006 Ports: tap_sel, tap_capture, tap_shift, tap_update, tap_tdi  in  1 each  user-chain TAP strobes and serial data in.
REQ-007 Ports: tap_tdo  out  1  serial data out.
REQ-008 Ports: bus_req  out  1  register access request; bus_wr  out  1  1 = write, 0 = read.
REQ-009 Ports: bus_addr  out  ADDR_W; bus_wdata  out  DATA_W.
REQ-010 Ports: bus_ack  in  1  access complete; bus_rdata  in  DATA_W  read data, valid with bus_ack.

Function
REQ-011 Frame width F = 1+ADDR_W+DATA_W; shift register sr[F-1:0]; tap_tdo = sr[0] combinationally.
REQ-012 Command frame layout: sr[0] = wr bit, sr[ADDR_W:1] = address, sr[F-1:ADDR_W+1] = write data.
REQ-013 tap_sel & tap_shift: sr <= {tap_tdi, sr[F-1:1]} each clk, LSB first.
REQ-014 tap_sel & tap_capture: sr <= {rdata_q, status field}; status field is ADDR_W+1 bits: bit0 = busy (state != IDLE), bit1 = timeout_flag, bit2 = overrun_flag, others 0.
REQ-015 Without tap_sel, or with no capture/shift strobe, sr holds its value.
REQ-016 Priority if several strobes coincide: capture > shift > update.
REQ-017 FSM states: IDLE, REQ.
REQ-018 IDLE, tap_sel & tap_update: latch wr/addr/wdata from sr into bus_wr/bus_addr/bus_wdata, clear timeout counter, go REQ; bus_req asserts the following cycle (1-cycle latency).
REQ-019 REQ: bus_req = 1; bus_wr/bus_addr/bus_wdata stable.
REQ-020 REQ with bus_ack = 1: go IDLE, bus_req = 0 next cycle; if read, rdata_q <= bus_rdata; if write, rdata_q unchanged.
REQ-021 REQ without bus_ack: counter increments; when TIMEOUT cycles elapse without ack, go IDLE, set timeout_flag, rdata_q unchanged.
REQ-022 bus_ack on the expiry cycle: ack wins, no timeout_flag.
REQ-023 bus_ack while IDLE is ignored.
REQ-024 tap_sel & tap_update while in REQ: command dropped, overrun_flag set, current access continues.
REQ-025 timeout_flag and overrun_flag are sticky and cleared by capture (read-to-clear); a set event in the same cycle as capture wins and is reported on the next capture.
REQ-026 Counter is 8 bits; never wraps (saturates at TIMEOUT).

Reset
REQ-027 reset asserted: sr = 0, state = IDLE, bus_req = 0, bus_wr = 0, bus_addr = 0, bus_wdata = 0, rdata_q = 0, both flags = 0, counter = 0; tap_tdo = 0.
REQ-028 reset mid-access in REQ: bus_req drops asynchronously, no rdata update, no flag set.

Verification
REQ-029 Write: shift frame wr=1, addr=0x5, data=0xA3, update -> bus_req one cycle later with bus_wr=1, bus_addr=5, bus_wdata=0xA3; ack after 3 cycles -> bus_req low next cycle.
REQ-030 Read: read of addr=0x2, bus_rdata=0x3C with ack; then capture+shift F bits -> tap_tdo stream shows status 0 then data 0x3C LSB first.
REQ-031 Timeout: read, never ack -> bus_req low after 15 cycles; capture shows status bit1 = 1; second capture shows bit1 = 0.
REQ-032 Overrun: update again while bus_req high -> bus_addr unchanged, capture shows bit2 = 1 and bit0 = 1.
REQ-033 Boundary: ack on cycle 15 of TIMEOUT=15 -> rdata_q updated, timeout_flag 0; timeout coincident with capture -> flag reported on following capture.
REQ-034 Reset during REQ -> all outputs at reset values immediately; new command after release executes normally.
